posit_round_rne: RTL and testbench

Parametrised posit rounding stage. It takes the normalised mantissa, regime value `k`, exponent and sign produced by the posit arithmetic datapath. It computes how many fraction bits survive encoding for the given regime, then rounds the fraction to that length using round-to-nearest-even. Fraction carry is propagated into the exponent and regime, and out-of-range regimes saturate to maxpos/minpos. It sits between the normaliser and the posit encoder and uses a start/done handshake.

---
 rtl/posit_round_rne_if.sv | 43 ++++
 rtl/posit_round_rne.sv | 224 ++++++++++++++++++++++
 tb/tb_posit_round_rne.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/posit_round_rne_if.sv
// Start/done bundle between the posit normaliser and encoder.
// Master drives the operand and start, slave returns the rounded fields.
interface posit_round_rne_if #(
  parameter int N  = 32,
  parameter int ES = 3,
  parameter int MW = 64,
  parameter int KW = 6
) ();
  localparam int FW  = N - ES - 3;
  localparam int NBW = $clog2(FW + 1);

  logic           start;
  logic [MW-1:0]  mant_in;
  logic [KW-1:0]  k_in;
  logic [ES-1:0]  exp_in;
  logic           sign_in;
  logic           zero_in;
  logic [FW-1:0]  frac_out;
  logic [NBW-1:0] nbt_out;
  logic [KW-1:0]  k_out;
  logic [ES-1:0]  exp_out;
  logic           sign_out;
  logic           inexact;
  logic           sat;
  logic           busy;
  logic           done;

  modport master (
    output start, mant_in, k_in,
    output exp_in, sign_in, zero_in,
    input  frac_out, nbt_out, k_out,
    input  exp_out, sign_out, inexact,
    input  sat, busy, done
  );

  modport slave (
    input  start, mant_in, k_in,
    input  exp_in, sign_in, zero_in,
    output frac_out, nbt_out, k_out,
    output exp_out, sign_out, inexact,
    output sat, busy, done
  );
endinterface

// File: rtl/posit_round_rne.sv
// Posit fraction rounding (round-to-nearest-even) with
// carry into exponent/regime and maxpos/minpos saturation.
module posit_round_rne #(
  parameter int N  = 32,
  parameter int ES = 3,
  parameter int MW = 64,
  parameter int KW = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  posit_round_rne_if.slave bus
);
  localparam int FW  = N - ES - 3;
  localparam int NBW = $clog2(FW + 1);
  localparam int FRW = MW - 2;

  localparam logic [NBW-1:0] FWB = NBW'(FW);
  localparam logic signed [KW-1:0] KMAX_S = KW'(N - ES - 3);
  localparam logic signed [KW-1:0] KMIN_S = KW'(-(N - ES - 2));
  localparam logic signed [KW-1:0] KSAT_P = KW'(N - 2);
  localparam logic signed [KW-1:0] KSAT_N = KW'(-(N - 2));

  typedef enum logic [2:0] {
    IDLE, LOAD, ROUND, ADJUST, DONE
  } state_t;

  function automatic logic [NBW-1:0] f_nbt(
    input logic signed [KW-1:0] k
  );
    int t;
    t = (k >= 0) ? FW - int'(k)
                 : FW + 1 + int'(k);
    return t[NBW-1:0];
  endfunction

  state_t                r_state;
  logic [FRW-1:0]        r_frac;
  logic signed [KW-1:0]  r_k;
  logic [ES-1:0]         r_exp;
  logic                  r_sign;
  logic                  r_zero;
  logic                  r_oor;
  logic [NBW-1:0]        r_nbt;
  logic [FW-1:0]         r_mask;
  logic [FW:0]           r_sum;
  logic                  r_inx;

  logic [FW-1:0]         r_sfrac;
  logic [NBW-1:0]        r_snbt;
  logic signed [KW-1:0]  r_sk;
  logic [ES-1:0]         r_sexp;
  logic                  r_ssign;
  logic                  r_sinx;
  logic                  r_ssat;

  logic [FW-1:0]         r_frac_o;
  logic [NBW-1:0]        r_nbt_o;
  logic [KW-1:0]         r_k_o;
  logic [ES-1:0]         r_exp_o;
  logic                  r_sign_o;
  logic                  r_inx_o;
  logic                  r_sat_o;
  logic                  r_busy;
  logic                  r_done;

  logic                  w_unused;
  logic [NBW-1:0]        w_nbt;
  logic                  w_oor;
  logic [FW-1:0]         w_kept;
  logic [FRW-1:0]        w_low;
  logic                  w_g;
  logic                  w_s;
  logic [FW:0]           w_inc;
  logic                  w_lsb;
  logic                  w_up;
  logic                  w_carry;
  logic                  w_ewrap;
  logic [ES-1:0]         w_exp_n;
  logic signed [KW-1:0]  w_k_n;
  logic                  w_sat;
  logic                  w_sat_nz;
  logic signed [KW-1:0]  w_ksat;

  assign w_unused = ^bus.mant_in[MW-1:MW-2];

  assign w_nbt = f_nbt(r_k);
  assign w_oor = (r_k > KMAX_S) ||
                 (r_k < KMIN_S);

  // Shifting the kept field out leaves G at the top, sticky below.
  assign w_kept = r_frac[FRW-1 -: FW] & r_mask;
  assign w_low  = r_frac << r_nbt;
  assign w_g    = w_low[FRW-1];
  assign w_s    = |w_low[FRW-2:0];
  assign w_inc  = {{FW{1'b0}}, 1'b1}
                  << (FWB - r_nbt);
  assign w_lsb  = |(w_kept & w_inc[FW-1:0]);
  assign w_up   = w_g & (w_s | w_lsb);

  assign w_carry  = r_sum[FW];
  assign w_ewrap  = w_carry && (r_exp == '1);
  assign w_exp_n  = r_exp + ES'(w_carry);
  assign w_k_n    = r_k + KW'(w_ewrap);
  assign w_sat    = r_oor ||
                    (w_ewrap && r_k == KMAX_S);
  assign w_sat_nz = !r_zero && w_sat;
  assign w_ksat   = (r_oor && r_k < 0) ? KSAT_N
                                       : KSAT_P;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_frac   <= '0;
      r_k      <= '0;
      r_exp    <= '0;
      r_sign   <= 1'b0;
      r_zero   <= 1'b0;
      r_oor    <= 1'b0;
      r_nbt    <= '0;
      r_mask   <= '0;
      r_sum    <= '0;
      r_inx    <= 1'b0;
      r_sfrac  <= '0;
      r_snbt   <= '0;
      r_sk     <= '0;
      r_sexp   <= '0;
      r_ssign  <= 1'b0;
      r_sinx   <= 1'b0;
      r_ssat   <= 1'b0;
      r_frac_o <= '0;
      r_nbt_o  <= '0;
      r_k_o    <= '0;
      r_exp_o  <= '0;
      r_sign_o <= 1'b0;
      r_inx_o  <= 1'b0;
      r_sat_o  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_frac  <= bus.mant_in[FRW-1:0];
            r_k     <= bus.k_in;
            r_exp   <= bus.exp_in;
            r_sign  <= bus.sign_in;
            r_zero  <= bus.zero_in;
            r_busy  <= 1'b1;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          r_nbt   <= w_nbt;
          r_oor   <= w_oor;
          r_mask  <= ~({FW{1'b1}} >> w_nbt);
          r_state <= ROUND;
        end
        ROUND: begin
          r_sum   <= {1'b0, w_kept} +
                     (w_up ? w_inc : '0);
          r_inx   <= w_g | w_s;
          r_state <= ADJUST;
        end
        ADJUST: begin
          unique case (1'b1)
            r_zero: begin
              r_sfrac <= '0;
              r_snbt  <= '0;
              r_sk    <= '0;
              r_sexp  <= '0;
              r_ssign <= 1'b0;
              r_sinx  <= 1'b0;
              r_ssat  <= 1'b0;
            end
            w_sat_nz: begin
              r_sfrac <= '0;
              r_snbt  <= '0;
              r_sk    <= w_ksat;
              r_sexp  <= '0;
              r_ssign <= r_sign;
              r_sinx  <= 1'b1;
              r_ssat  <= 1'b1;
            end
            default: begin
              r_sfrac <= w_carry ? '0
                                 : r_sum[FW-1:0];
              r_snbt  <= f_nbt(w_k_n);
              r_sk    <= w_k_n;
              r_sexp  <= w_exp_n;
              r_ssign <= r_sign;
              r_sinx  <= r_inx;
              r_ssat  <= 1'b0;
            end
          endcase
          r_state <= DONE;
        end
        DONE: begin
          r_frac_o <= r_sfrac;
          r_nbt_o  <= r_snbt;
          r_k_o    <= r_sk;
          r_exp_o  <= r_sexp;
          r_sign_o <= r_ssign;
          r_inx_o  <= r_sinx;
          r_sat_o  <= r_ssat;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.frac_out = r_frac_o;
  assign bus.nbt_out  = r_nbt_o;
  assign bus.k_out    = r_k_o;
  assign bus.exp_out  = r_exp_o;
  assign bus.sign_out = r_sign_o;
  assign bus.inexact  = r_inx_o;
  assign bus.sat      = r_sat_o;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
endmodule

// File: tb/tb_posit_round_rne.sv
// Bench for posit_round_rne: directed cases plus random
// operands checked against an integer rounding model.
module tb_posit_round_rne;
  localparam int N  = 32;
  localparam int ES = 3;
  localparam int MW = 64;
  localparam int KW = 6;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  posit_round_rne_if #(
    .N(N), .ES(ES), .MW(MW), .KW(KW)
  ) bus ();

  posit_round_rne #(
    .N(N), .ES(ES), .MW(MW), .KW(KW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [25:0] frac;
    logic [4:0]  nbt;
    logic [5:0]  k;
    logic [2:0]  e;
    logic        s;
    logic        inx;
    logic        sat;
  } res_t;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] want);
    n_chk++;
    assert (got === want) n_pass++;
    else $error("FAIL %s: got %0h want %0h",
                tag, got, want);
  endtask

  function automatic res_t model(
    input logic [63:0] m, input int k0,
    input int e0, input bit s, input bit z);
    res_t r;
    longint unsigned f, kept, rem, half;
    int nbt, k, e;
    bit up;
    r = '0;
    k = k0;
    e = e0;
    if (z) return r;
    r.s = s;
    if (k > 26 || k < -27) begin
      r.sat = 1'b1;
      r.inx = 1'b1;
      r.k   = (k < 0) ? 6'(-30) : 6'(30);
      return r;
    end
    nbt  = (k >= 0) ? 26 - k : 27 + k;
    f    = m & 64'h3FFF_FFFF_FFFF_FFFF;
    kept = f >> (62 - nbt);
    rem  = f - (kept << (62 - nbt));
    half = 64'd1 << (61 - nbt);
    r.inx = (rem != 0);
    up = (rem > half) ||
         (rem == half && (kept % 2) == 1);
    if (up) kept = kept + 1;
    if (kept == (64'd1 << nbt)) begin
      kept = 0;
      e = e + 1;
      if (e == 8) begin
        e = 0;
        k = k + 1;
      end
    end
    if (k > 26) begin
      r.sat = 1'b1;
      r.inx = 1'b1;
      r.k   = 6'(30);
      return r;
    end
    nbt    = (k >= 0) ? 26 - k : 27 + k;
    r.k    = 6'(k);
    r.e    = 3'(e);
    r.nbt  = 5'(nbt);
    r.frac = 26'(kept << (26 - nbt));
    return r;
  endfunction

  task automatic scramble();
    bus.mant_in = {$urandom, $urandom};
    bus.k_in    = 6'($urandom);
    bus.exp_in  = 3'($urandom);
    bus.sign_in = 1'($urandom);
    bus.zero_in = 1'($urandom);
  endtask

  task automatic run_op(input logic [63:0] m,
                        input int k, input int e,
                        input bit s, input bit z,
                        input int glitch);
    res_t want;
    int lat, nd;
    want = model(m, k, e, s, z);
    @(negedge clk);
    bus.mant_in = m;
    bus.k_in    = 6'(k);
    bus.exp_in  = 3'(e);
    bus.sign_in = s;
    bus.zero_in = z;
    bus.start   = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    scramble();
    chk("busy", bus.busy, 1);
    lat = -1;
    nd  = 0;
    for (int c = 1; c <= 12; c++) begin
      if (c == glitch) bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      if (bus.done) begin
        nd++;
        if (lat < 0) begin
          lat = c;
          chk("frac", bus.frac_out, want.frac);
          chk("nbt", bus.nbt_out, want.nbt);
          chk("k", bus.k_out, want.k);
          chk("exp", bus.exp_out, want.e);
          chk("sign", bus.sign_out, want.s);
          chk("inexact", bus.inexact, want.inx);
          chk("sat", bus.sat, want.sat);
        end
      end
    end
    chk("latency", 64'(lat), 4);
    chk("ndone", 64'(nd), 1);
    chk("idle_busy", bus.busy, 0);
  endtask

  initial begin
    logic [63:0] m;
    int k, e, nd;
    bus.start   = 1'b0;
    bus.mant_in = '0;
    bus.k_in    = '0;
    bus.exp_in  = '0;
    bus.sign_in = 1'b0;
    bus.zero_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_frac", bus.frac_out, 0);
    chk("rst_k", bus.k_out, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(64'h4000_0000_0000_0000, 0, 2, 0, 0, 0);
    chk("exact_nbt", bus.nbt_out, 26);
    chk("exact_exp", bus.exp_out, 2);
    chk("exact_inx", bus.inexact, 0);

    run_op(64'h4000_0008_0000_0000, 0, 1, 0, 0, 0);
    chk("tie_dn_frac", bus.frac_out, 0);
    chk("tie_dn_inx", bus.inexact, 1);
    run_op(64'h4000_0018_0000_0000, 0, 1, 1, 0, 0);
    chk("tie_up_frac", bus.frac_out, 2);

    run_op(64'h7FFF_FFF8_0000_0000, 0, 7, 0, 0, 0);
    chk("carry_k", bus.k_out, 1);
    chk("carry_exp", bus.exp_out, 0);
    chk("carry_nbt", bus.nbt_out, 25);
    run_op(64'h7FFF_FFF8_0000_0000, 26, 7, 0, 0, 0);
    chk("carry_sat", bus.sat, 1);
    chk("carry_satk", bus.k_out, 30);

    run_op(64'h5000_0000_0000_0001, -5, 4, 0, 0, 0);
    chk("neg_nbt", bus.nbt_out, 22);
    chk("neg_frac", bus.frac_out, 26'h1000000);
    chk("neg_inx", bus.inexact, 1);

    run_op(64'h4000_0000_0000_0000, 27, 3, 0, 0, 0);
    chk("max_k", bus.k_out, 30);
    run_op(64'h4000_0000_0000_0000, -28, 3, 1, 0, 0);
    chk("min_k", bus.k_out, 6'h22);
    chk("min_sat", bus.sat, 1);
    run_op(64'h7123_4567_89AB_CDEF, 3, 5, 1, 1, 0);
    chk("zero_inx", bus.inexact, 0);
    chk("zero_k", bus.k_out, 0);

    run_op(64'h4ABC_0000_0000_0000, 1, 6, 0, 0, 2);
    run_op(64'h4ABC_0000_0000_0000, -2, 6, 1, 0, 4);

    run_op(64'h4000_0000_0000_0000, 0, 2, 0, 0, 0);
    @(negedge clk);
    bus.mant_in = 64'h7FFF_FFF8_0000_0000;
    bus.k_in    = 6'd0;
    bus.exp_in  = 3'd5;
    bus.zero_in = 1'b0;
    bus.start   = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_exp", bus.exp_out, 0);
    chk("arst_nbt", bus.nbt_out, 0);
    chk("arst_busy", bus.busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (bus.done) nd++;
    end
    chk("arst_nodone", 64'(nd), 0);
    run_op(64'h4000_0018_0000_0000, 0, 1, 0, 0, 0);

    for (int i = 0; i < 150; i++) begin
      m = {$urandom, $urandom};
      m[63] = 1'b0;
      m[62] = 1'b1;
      case ($urandom_range(0, 3))
        1: m[34:0]  = '0;
        2: m[61:30] = '1;
        default: ;
      endcase
      k = int'($urandom_range(0, 59)) - 30;
      e = int'($urandom_range(0, 7));
      run_op(m, k, e, 1'($urandom),
             ($urandom_range(0, 11) == 0), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
